// File: rtl/alu_pkg.sv
// alu_pkg: opcode and flag types shared by alu_pipe and alu_core
package alu_pkg;
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_XOR  = 3'b001,
        OP_NAND = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_SHL  = 3'b110,
        OP_SHR  = 3'b111
    } opcode_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic overflow;
    } flags_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit ALU producing result plus carry/zero/overflow
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  opcode_t          op_i,
    output logic [WIDTH-1:0] res_o,
    output flags_t           flags_o
);
    logic [WIDTH:0] sum, dif, shl, shr;
    logic [SHW-1:0] sh;

    always_comb begin
        sh = b_i[SHW-1:0];
        sum = {1'b0, a_i} + {1'b0, b_i};
        dif = {1'b0, a_i} - {1'b0, b_i};
        // one guard bit on each shift catches the last bit shifted out
        shl = {1'b0, a_i} << sh;
        shr = {a_i, 1'b0} >> sh;
        res_o = '0;
        flags_o = '0;
        case (op_i)
            OP_ADD: begin
                res_o = sum[WIDTH-1:0];
                flags_o.carry = sum[WIDTH];
                flags_o.overflow = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                res_o = dif[WIDTH-1:0];
                flags_o.carry = ~dif[WIDTH];
                flags_o.overflow = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (dif[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_XOR:  res_o = a_i ^ b_i;
            OP_NAND: res_o = ~(a_i & b_i);
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_SHL: begin
                res_o = shl[WIDTH-1:0];
                flags_o.carry = shl[WIDTH];
            end
            OP_SHR: begin
                res_o = shr[WIDTH:1];
                flags_o.carry = shr[0];
            end
        endcase
        flags_o.zero = (res_o == '0);
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: one-stage registered ALU with valid/ready handshakes and an accumulator
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] acc
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] op_a, res, out_q, out_d, acc_q, acc_d;
    flags_t           fl, flags_q, flags_d;
    logic             out_valid_q, out_valid_d, accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign op_a     = use_acc ? acc_q : a;

    alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
        .a_i    (op_a),
        .b_i    (b),
        .op_i   (opcode_t'(opcode)),
        .res_o  (res),
        .flags_o(fl)
    );

    always_comb begin
        out_d = accept ? res : out_q;
        flags_d = accept ? fl : flags_q;
        out_valid_d = accept || (out_valid_q && !out_ready);
        // clear wins over a same-edge accumulate write
        acc_d = acc_clr ? '0 : (accept && acc_en) ? res : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            flags_q <= '0;
            out_valid_q <= 1'b0;
            acc_q <= '0;
        end else begin
            out_q <= out_d;
            flags_q <= flags_d;
            out_valid_q <= out_valid_d;
            acc_q <= acc_d;
        end
    end

    assign out       = out_q;
    assign carry     = flags_q.carry;
    assign zero      = flags_q.zero;
    assign overflow  = flags_q.overflow;
    assign out_valid = out_valid_q;
    assign acc       = acc_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe with an integer-arithmetic reference model
module tb_alu_pipe;
    localparam int W = 8;

    typedef struct packed {
        logic [7:0] o;
        logic       c;
        logic       z;
        logic       v;
    } exp_t;

    logic clk, rst_n, in_valid, in_ready, use_acc, acc_en, acc_clr;
    logic out_valid, out_ready, carry, zero, overflow;
    logic [2:0] opcode;
    logic [7:0] a, b, out, acc;

    logic in_valid16, in_ready16, out_valid16, carry16, zero16, ovf16;
    logic [15:0] a16, b16, out16, acc16;

    exp_t q[$];
    logic mv;
    logic [7:0] acc_m;
    int nvec = 0, nerr = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .use_acc(use_acc), .acc_en(acc_en),
        .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .carry(carry), .zero(zero), .overflow(overflow), .acc(acc)
    );

    alu_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .opcode(3'b000), .a(a16), .b(b16), .use_acc(1'b0), .acc_en(1'b0),
        .acc_clr(1'b0), .out_valid(out_valid16), .out_ready(1'b1),
        .out(out16), .carry(carry16), .zero(zero16), .overflow(ovf16), .acc(acc16)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int op, input int x, input int y);
        int r, sx, sy, s, n;
        exp_t e;
        e = '0;
        n = y % W;
        sx = x >= 128 ? x - 256 : x;
        sy = y >= 128 ? y - 256 : y;
        case (op)
            0: begin r = x + y; e.c = r > 255; s = sx + sy; e.v = s > 127 || s < -128; end
            1: r = x ^ y;
            2: r = ~(x & y);
            3: begin r = x - y; e.c = x >= y; s = sx - sy; e.v = s > 127 || s < -128; end
            4: r = x & y;
            5: r = x | y;
            6: begin r = x << n; e.c = n > 0 && ((x >> (W - n)) & 1) == 1; end
            7: begin r = x >> n; e.c = n > 0 && ((x >> (n - 1)) & 1) == 1; end
            default: r = 0;
        endcase
        e.o = 8'(r & 255);
        e.z = (r & 255) == 0;
        return e;
    endfunction

    // reference: tracks pending-result state and accumulator from the handshake rules
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv = 0;
            acc_m = 0;
            q.delete();
        end else begin
            automatic logic ok = in_valid && (!mv || out_ready);
            automatic exp_t e = model(int'(opcode), int'(use_acc ? acc_m : a), int'(b));
            if (ok) q.push_back(e);
            mv = ok ? 1'b1 : (out_ready ? 1'b0 : mv);
            acc_m = acc_clr ? 8'h00 : (ok && acc_en) ? e.o : acc_m;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'(!mv || out_ready));
            chk("out_valid", 32'(out_valid), 32'(mv));
            chk("acc", 32'(acc), 32'(acc_m));
            if (mv) begin
                if (q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL scoreboard got=empty expected=entry at %0t", $time);
                end else begin
                    chk("result", 32'({out, carry, zero, overflow}), 32'(q[0]));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] xa, input logic [7:0] xb,
                         input logic ua = 0, input logic ae = 0, input logic ac = 0, input logic iv = 1);
        opcode = op; a = xa; b = xb; use_acc = ua; acc_en = ae; acc_clr = ac; in_valid = iv;
        @(posedge clk);
        #1;
        in_valid = 0;
        acc_clr = 0;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; opcode = 0; a = 0; b = 0; use_acc = 0;
        acc_en = 0; acc_clr = 0; out_ready = 1;
        in_valid16 = 0; a16 = 0; b16 = 0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_flags", 32'({out, carry, zero, overflow}), 0);
        chk("rst_acc", 32'(acc), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        issue(3'd0, 8'hFF, 8'h01);
        chk("add_ff_01", 32'({out, carry, zero, overflow}), 32'({8'h00, 3'b110}));
        chk("add_ff_01_valid", 32'(out_valid), 1);
        issue(3'd0, 8'h7F, 8'h01);
        chk("add_7f_01", 32'({out, carry, zero, overflow}), 32'({8'h80, 3'b001}));
        issue(3'd3, 8'h05, 8'h07);
        chk("sub_05_07", 32'({out, carry, zero, overflow}), 32'({8'hFE, 3'b000}));
        issue(3'd3, 8'h80, 8'h01);
        chk("sub_80_01", 32'({out, carry, zero, overflow}), 32'({8'h7F, 3'b101}));

        issue(3'd0, 8'h10, 8'h20);
        out_ready = 0; opcode = 0; a = 8'h33; b = 8'h00; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_hold", 32'({out, carry, zero, overflow, out_valid}), 32'({8'h30, 3'b000, 1'b1}));
        end
        out_ready = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        chk("bp_release", 32'({out, out_valid}), 32'({8'h33, 1'b1}));

        issue(3'd0, 8'h00, 8'h00, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            issue(3'd0, 8'h00, 8'h10, 1, 1);
            chk("acc_chain", 32'({out, out_valid}), 32'({8'((i + 1) * 16), 1'b1}));
        end
        chk("acc_chain_final", 32'(acc), 32'h40);

        issue(3'd6, 8'h81, 8'h01);
        chk("shl_81_1", 32'({out, carry, zero, overflow}), 32'({8'h02, 3'b100}));
        issue(3'd7, 8'h01, 8'h00);
        chk("shr_01_0", 32'({out, carry, zero, overflow}), 32'({8'h01, 3'b000}));
        issue(3'd2, 8'hFF, 8'hFF);
        chk("nand_ff_ff", 32'({out, carry, zero, overflow}), 32'({8'h00, 3'b010}));
        issue(3'd1, 8'hA5, 8'h5A);
        chk("xor_a5_5a", 32'({out, carry, zero, overflow}), 32'({8'hFF, 3'b000}));

        issue(3'd0, 8'h05, 8'h00, 0, 1);
        chk("acc_load", 32'(acc), 32'h05);
        issue(3'd0, 8'h01, 8'h01, 0, 1, 1);
        chk("clr_priority", 32'({out, acc}), 32'({8'h02, 8'h00}));
        issue(3'd0, 8'h09, 8'h00, 0, 1);
        chk("pre_reset", 32'({acc, out_valid}), 32'({8'h09, 1'b1}));
        rst_n = 0;
        #1;
        chk("reset_pulse", 32'({out_valid, acc, in_ready}), 32'({1'b0, 8'h00, 1'b1}));
        #1 rst_n = 1;

        a16 = 16'h00FF; b16 = 16'h0001; in_valid16 = 1;
        @(posedge clk);
        #1;
        in_valid16 = 0;
        chk("w16_add", 32'({out16, carry16, out_valid16}), 32'({16'h0100, 1'b0, 1'b1}));

        for (int i = 0; i < 400; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            opcode = 3'($urandom_range(0, 7));
            a = 8'($urandom);
            b = 8'($urandom);
            use_acc = $urandom_range(0, 3) == 0;
            acc_en = $urandom_range(0, 1) == 1;
            acc_clr = $urandom_range(0, 9) == 0;
            out_ready = $urandom_range(0, 9) < 7;
            @(posedge clk);
            #1;
        end
        in_valid = 0; acc_clr = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("drain", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
